// File: rtl/wb_mem_arbiter_pkg.sv
// Shared Wishbone definitions for the memory arbiter: cycle-type and burst-type codes,
// end-of-burst helper, and arbiter state encoding.
package wb_mem_arbiter_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic logic wb_is_last(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/wb_mem_arbiter_rr.sv
// Combinational round-robin picker: grants the first requester after the one-hot `last`,
// searching cyclically upward.
module wb_arb_rr #(
  parameter int NM = 2
) (
  input  logic [NM-1:0] req,
  input  logic [NM-1:0] last,
  output logic [NM-1:0] gnt
);

  always_comb begin
    int   base;
    logic found;
    base  = 0;
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NM; k++)
      if (last[k]) base = k;
    for (int i = 1; i <= NM; i++)
      for (int k = 0; k < NM; k++)
        if (!found && req[k] && (((base + i) % NM) == k)) begin
          gnt[k] = 1'b1;
          found  = 1'b1;
        end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone arbiter sharing one memory slave between NM masters; a grant is held
// until the master drops cyc. Optional stall timeout via WB_ARB_TIMEOUT_EN.
//
//   state    | meaning
//   ARB_IDLE | no grant; slave cyc/stb low; picks next requester after `last`
//   ARB_BUSY | one master owns the slave until it drops cyc
module wb_mem_arbiter
  import wb_mem_arbiter_pkg::*;
#(
  parameter int NM      = 2,
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [NM*aw-1:0] wbm_adr_i,
  input  logic [NM*dw-1:0] wbm_dat_i,
  input  logic [NM*4-1:0]  wbm_sel_i,
  input  logic [NM-1:0]    wbm_we_i,
  input  logic [NM*3-1:0]  wbm_cti_i,
  input  logic [NM*2-1:0]  wbm_bte_i,
  input  logic [NM-1:0]    wbm_cyc_i,
  input  logic [NM-1:0]    wbm_stb_i,
  output logic [dw-1:0]    wbm_dat_o,
  output logic [NM-1:0]    wbm_ack_o,
  output logic [NM-1:0]    wbm_err_o,
  output logic [aw-1:0]    wbs_adr_o,
  output logic [dw-1:0]    wbs_dat_o,
  output logic [3:0]       wbs_sel_o,
  output logic             wbs_we_o,
  output logic [2:0]       wbs_cti_o,
  output logic [1:0]       wbs_bte_o,
  output logic             wbs_cyc_o,
  output logic             wbs_stb_o,
  input  logic [dw-1:0]    wbs_dat_i,
  input  logic             wbs_ack_i,
  input  logic             wbs_err_i,
  output logic [NM-1:0]    grant_o
);

  arb_state_e    state_q, state_d;
  logic [NM-1:0] grant_q, grant_d, last_q, last_d, pick;
  logic          busy, g_cyc, g_stb, to_hold, to_fire;

  wb_arb_rr #(.NM(NM)) u_rr (.req(wbm_cyc_i), .last(last_q), .gnt(pick));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= {1'b1, {(NM-1){1'b0}}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: if (|wbm_cyc_i) begin
        grant_d = pick;
        state_d = ARB_BUSY;
      end
      ARB_BUSY: if (!(|(grant_q & wbm_cyc_i))) begin
        last_d  = grant_q;
        grant_d = '0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    g_cyc     = 1'b0;
    g_stb     = 1'b0;
    for (int k = 0; k < NM; k++)
      if (grant_q[k]) begin
        wbs_adr_o = wbm_adr_i[k*aw +: aw];
        wbs_dat_o = wbm_dat_i[k*dw +: dw];
        wbs_sel_o = wbm_sel_i[k*4 +: 4];
        wbs_we_o  = wbm_we_i[k];
        wbs_cti_o = wbm_cti_i[k*3 +: 3];
        wbs_bte_o = wbm_bte_i[k*2 +: 2];
        g_cyc     = wbm_cyc_i[k];
        g_stb     = wbm_stb_i[k];
      end
  end

  assign busy      = (state_q == ARB_BUSY);
  assign grant_o   = grant_q;
  assign wbs_cyc_o = busy & g_cyc & ~to_hold;
  assign wbs_stb_o = busy & g_cyc & g_stb & ~to_hold;
  assign wbm_dat_o = wb_rst_i ? '0 : wbs_dat_i;
  assign wbm_ack_o = (busy & ~wb_rst_i & ~to_hold & wbs_ack_i) ? grant_q : '0;
  assign wbm_err_o = (busy & ~wb_rst_i & (wbs_err_i | to_fire)) ? grant_q : '0;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CL = $clog2(TIMEOUT + 1);
  localparam int CW = (CL < 8) ? 8 : ((CL > 16) ? 16 : CL);

  logic [CW-1:0] cnt_q;
  logic          hold_q, stall;

  // cnt_q counts stalls already seen, so firing on TIMEOUT-1 flags the TIMEOUT-th stall cycle
  assign stall   = busy & g_cyc & g_stb & ~hold_q & ~wbs_ack_i & ~wbs_err_i;
  assign to_fire = stall & (cnt_q == CW'(TIMEOUT - 1));
  assign to_hold = hold_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q  <= '0;
      hold_q <= 1'b0;
    end else if (!busy) begin
      cnt_q  <= '0;
      hold_q <= 1'b0;
    end else if (to_fire) begin
      cnt_q  <= '0;
      hold_q <= 1'b1;
    end else if (stall) begin
      cnt_q  <= cnt_q + 1'b1;
    end else begin
      cnt_q  <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign to_hold        = 1'b0;
  assign to_fire        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Randomized bench for wb_mem_arbiter: round-robin reference model, bus-mux checks and a
// simple registered-ack memory slave. Build with WB_ARB_TIMEOUT_EN to cover the timeout path.
module tb_wb_mem_arbiter;
  import wb_mem_arbiter_pkg::*;

  localparam int NM = 2;
  localparam int DW = 32;
  localparam int AW = 32;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m_adr [NM];
  logic [DW-1:0] m_dat [NM];
  logic [3:0]    m_sel [NM];
  logic          m_we  [NM];
  logic [2:0]    m_cti [NM];
  logic [1:0]    m_bte [NM];
  logic          m_cyc [NM];
  logic          m_stb [NM];

  logic [NM*AW-1:0] f_adr;
  logic [NM*DW-1:0] f_dat;
  logic [NM*4-1:0]  f_sel;
  logic [NM-1:0]    f_we, f_cyc, f_stb;
  logic [NM*3-1:0]  f_cti;
  logic [NM*2-1:0]  f_bte;

  logic [DW-1:0] wbm_dat_o, wbs_dat_o, wbs_dat_i;
  logic [NM-1:0] wbm_ack_o, wbm_err_o, grant_o;
  logic [AW-1:0] wbs_adr_o;
  logic [3:0]    wbs_sel_o;
  logic          wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_ack_i, wbs_err_i;
  logic [2:0]    wbs_cti_o;
  logic [1:0]    wbs_bte_o;

  always_comb begin
    f_adr = '0; f_dat = '0; f_sel = '0; f_we = '0;
    f_cti = '0; f_bte = '0; f_cyc = '0; f_stb = '0;
    for (int k = 0; k < NM; k++) begin
      f_adr[k*AW +: AW] = m_adr[k];
      f_dat[k*DW +: DW] = m_dat[k];
      f_sel[k*4 +: 4]   = m_sel[k];
      f_we[k]           = m_we[k];
      f_cti[k*3 +: 3]   = m_cti[k];
      f_bte[k*2 +: 2]   = m_bte[k];
      f_cyc[k]          = m_cyc[k];
      f_stb[k]          = m_stb[k];
    end
  end

  wb_mem_arbiter #(.NM(NM), .dw(DW), .aw(AW), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(f_adr), .wbm_dat_i(f_dat), .wbm_sel_i(f_sel), .wbm_we_i(f_we),
    .wbm_cti_i(f_cti), .wbm_bte_i(f_bte), .wbm_cyc_i(f_cyc), .wbm_stb_i(f_stb),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .grant_o(grant_o)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] w);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Slave: registered single-cycle response, optionally an error, or silent when muted
  logic resp, resp_err, mute, err_en;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp     <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      resp     <= wbs_cyc_o & wbs_stb_o & ~resp & ~mute;
      resp_err <= err_en && ($urandom_range(0, 7) == 0);
    end
  end
  assign wbs_ack_i = resp & ~resp_err;
  assign wbs_err_i = resp & resp_err;
  assign wbs_dat_i = mem_word(wbs_adr_o >> 2);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: integer owner index and round-robin pointer
  int holder = -1;
  int last   = NM - 1;
  int gseq[$];
  logic [NM-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    logic [NM-1:0] exp_g;
    int  g;
    bit  found;
    if (rst) begin
      check("rst_grant", grant_o, 0);
      check("rst_ack", wbm_ack_o, 0);
      check("rst_err", wbm_err_o, 0);
      check("rst_scyc", wbs_cyc_o, 0);
      check("rst_dat", wbm_dat_o, 0);
      holder   = -1;
      last     = NM - 1;
      prev_gnt = '0;
    end else begin
      exp_g = '0;
      if (holder >= 0) exp_g[holder] = 1'b1;
      check("grant", grant_o, exp_g);
      check("ack_route", wbm_ack_o, wbs_ack_i ? exp_g : '0);
      if (!mute) begin
        check("err_route", wbm_err_o, wbs_err_i ? exp_g : '0);
        check("slave_cyc", wbs_cyc_o, (holder >= 0) && m_cyc[holder]);
        check("slave_stb", wbs_stb_o, (holder >= 0) && m_cyc[holder] && m_stb[holder]);
      end
      if (grant_o != 0 && prev_gnt == 0) begin
        g = -1;
        for (int k = 0; k < NM; k++) if (grant_o[k]) g = k;
        gseq.push_back(g);
      end
      prev_gnt = grant_o;
      if (holder < 0) begin
        found = 1'b0;
        for (int i = 1; i <= NM; i++)
          if (!found && m_cyc[(last + i) % NM]) begin
            holder = (last + i) % NM;
            found  = 1'b1;
          end
      end else if (!m_cyc[holder]) begin
        last   = holder;
        holder = -1;
      end
    end
  end

  task automatic wait_resp(input int k);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(wbm_ack_o[k] || wbm_err_o[k]) && n < 100);
    check($sformatf("m%0d_resp", k), wbm_ack_o[k] | wbm_err_o[k], 1);
  endtask

  task automatic xfer(input int k, input int beats, output int acks);
    acks = 0;
    @(posedge clk); #1;
    m_adr[k] = AW'($urandom_range(0, 255)) << 2;
    m_we[k]  = 1'($urandom_range(0, 1));
    m_dat[k] = $urandom;
    m_sel[k] = 4'($urandom_range(1, 15));
    m_bte[k] = BTE_LINEAR;
    m_cti[k] = (beats > 1) ? CTI_INC : CTI_CLASSIC;
    m_cyc[k] = 1'b1;
    m_stb[k] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      if (beats > 1 && b == beats - 1) m_cti[k] = CTI_EOB;
      wait_resp(k);
      check($sformatf("m%0d_adr", k), wbs_adr_o, m_adr[k]);
      check($sformatf("m%0d_we", k), wbs_we_o, m_we[k]);
      check($sformatf("m%0d_sel", k), wbs_sel_o, m_sel[k]);
      check($sformatf("m%0d_wdat", k), wbs_dat_o, m_dat[k]);
      check($sformatf("m%0d_cti", k), wbs_cti_o, m_cti[k]);
      if (!m_we[k]) check($sformatf("m%0d_rdat", k), wbm_dat_o, mem_word(m_adr[k] >> 2));
      acks += int'(wbm_ack_o[k]);
      @(posedge clk); #1;
      m_adr[k] = m_adr[k] + 4;
      m_dat[k] = $urandom;
    end
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
    m_cti[k] = CTI_CLASSIC;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int gs(input int i);
    return (i < gseq.size()) ? gseq[i] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a0, a1, n;
    mute = 1'b0;
    err_en = 1'b0;
    for (int k = 0; k < NM; k++) begin
      m_adr[k] = '0; m_dat[k] = '0; m_sel[k] = '0; m_we[k] = 1'b0;
      m_cti[k] = CTI_CLASSIC; m_bte[k] = BTE_LINEAR; m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
    end
    #1 rst = 1'b1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cyc[1] = 1'b0;
    rst = 1'b0;
    idle(2);

    // single classic read from m0
    m_adr[0] = 32'h10; m_we[0] = 1'b0; m_sel[0] = 4'hF; m_cti[0] = CTI_CLASSIC;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(negedge clk);
    check("single_lat", wbs_cyc_o, 0);
    @(negedge clk);
    check("single_cyc", wbs_cyc_o, 1);
    check("single_gnt", grant_o, 2'b01);
    wait_resp(0);
    check("single_ack", wbm_ack_o, 2'b01);
    check("single_dat", wbm_dat_o, mem_word(4));
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    idle(2);

    // contention from reset: m0 first, m1 next
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    gseq.delete();
    fork
      xfer(0, 1, a0);
      xfer(1, 1, a1);
    join
    idle(3);
    check("cont_n", gseq.size(), 2);
    check("cont_first", gs(0), 0);
    check("cont_second", gs(1), 1);

    // 4-beat incrementing burst is not split by m1
    gseq.delete();
    fork
      xfer(0, 4, a0);
      begin @(posedge clk); #1; xfer(1, 1, a1); end
    join
    idle(3);
    check("burst_acks", a0, 4);
    check("burst_order0", gs(0), 0);
    check("burst_order1", gs(1), 1);

    // fairness with both masters always requesting
    gseq.delete();
    fork
      for (int t = 0; t < 4; t++) xfer(0, $urandom_range(1, 3), a0);
      for (int t = 0; t < 4; t++) xfer(1, $urandom_range(1, 3), a1);
    join
    idle(3);
    check("fair_n", gseq.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("fair_%0d", i), gs(i), i % 2);

    // random traffic with slave errors
    err_en = 1'b1;
    fork
      for (int t = 0; t < 8; t++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        xfer(0, $urandom_range(1, 4), a0);
      end
      for (int t = 0; t < 8; t++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        xfer(1, $urandom_range(1, 4), a1);
      end
    join
    err_en = 1'b0;
    idle(3);

    // async reset in the middle of a burst
    m_adr[0] = 32'h40; m_we[0] = 1'b0; m_sel[0] = 4'hF; m_cti[0] = CTI_INC;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      wait_resp(0);
      @(posedge clk); #1;
      m_adr[0] = m_adr[0] + 4;
    end
    #1 rst = 1'b1;
    #1;
    check("mid_rst_cyc", wbs_cyc_o, 0);
    check("mid_rst_gnt", grant_o, 0);
    check("mid_rst_ack", wbm_ack_o, 0);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cti[0] = CTI_CLASSIC;
    @(posedge clk); #1 rst = 1'b0;
    gseq.delete();
    fork
      xfer(0, 1, a0);
      xfer(1, 1, a1);
    join
    idle(3);
    check("post_rst_first", gs(0), 0);

    // silent slave: stall timeout
    mute = 1'b1;
    m_adr[0] = 32'h80; m_cti[0] = CTI_CLASSIC; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!grant_o[0] && n < 10);
    check("to_gnt", grant_o[0], 1);
    for (int s = 1; s <= 7; s++) begin
      if (s > 1) @(negedge clk);
      check($sformatf("to_err_%0d", s), wbm_err_o[0], TO_EN && (s == 4));
      check($sformatf("to_cyc_%0d", s), wbs_cyc_o, !TO_EN || (s <= 4));
    end
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    idle(2);
    mute = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
